// File: rtl/sound_i2s_tx.sv
// Mono sample to Philips I2S serializer: requests one sample per frame, buffers it,
// and shifts it out MSB-first on both slots with a counter-derived bit clock.
module sound_i2s_tx #(
    parameter int pBclkDiv     = 32,
    parameter int pSampleWidth = 16
) (
    input  logic                    iSysClk,
    input  logic                    iRst,
    input  logic [pSampleWidth-1:0] iSound,
    input  logic                    iSoundVd,
    input  logic                    iMute,
    output logic                    oSoundCke,
    output logic                    oBclk,
    output logic                    oLrck,
    output logic                    oSdata,
    output logic                    oUnderrun,
    output logic                    oOverrun
);

    localparam int DIV_W   = (pBclkDiv > 1) ? $clog2(pBclkDiv) : 1;
    localparam int FRAME_W = 2 * pSampleWidth;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(pBclkDiv - 1);

    logic [DIV_W-1:0]        div_q, div_d;
    logic                    bclk_q, bclk_d;
    logic [4:0]              bit_cnt_q, bit_cnt_d;
    logic [pSampleWidth-1:0] hold_q, hold_d;
    logic                    hold_vd_q, hold_vd_d;
    logic [pSampleWidth-1:0] last_q, last_d;
    logic [FRAME_W-1:0]      shift_q, shift_d;
    logic                    lrck_q, lrck_d;
    logic                    sdata_q, sdata_d;
    logic                    cke_q, cke_d;
    logic                    und_q, und_d;
    logic                    ovr_q, ovr_d;
    logic                    start_q, start_d;

    logic                    fall_s;
    logic                    load_s;
    logic [4:0]              bit_nxt_s;
    logic [pSampleWidth-1:0] sample_s;
    logic [FRAME_W-1:0]      frame_s;

    // Next-state logic: divider, falling-edge sequencing, frame load and sample capture
    always_comb begin
        div_d     = div_q;
        bclk_d    = bclk_q;
        bit_cnt_d = bit_cnt_q;
        hold_d    = hold_q;
        hold_vd_d = hold_vd_q;
        last_d    = last_q;
        shift_d   = shift_q;
        lrck_d    = lrck_q;
        sdata_d   = sdata_q;
        cke_d     = start_q;
        und_d     = 1'b0;
        ovr_d     = 1'b0;
        start_d   = 1'b0;
        fall_s    = 1'b0;
        load_s    = 1'b0;
        sample_s  = last_q;
        frame_s   = '0;
        bit_nxt_s = bit_cnt_q + 5'd1;

        if (div_q == DIV_LAST) begin
            div_d  = '0;
            bclk_d = ~bclk_q;
            fall_s = bclk_q;
        end else begin
            div_d  = div_q + DIV_W'(1);
        end

        if (fall_s) begin
            bit_cnt_d = bit_nxt_s;
            lrck_d    = bit_nxt_s[4];
            if (bit_nxt_s == 5'd1) begin
                // The MSB leaves on the load event itself: one-bit I2S delay after LRCK.
                load_s = 1'b1;
                if (hold_vd_q) begin
                    sample_s = hold_q;
                    last_d   = hold_q;
                end else begin
                    sample_s = last_q;
                    und_d    = 1'b1;
                end
                frame_s = iMute ? {FRAME_W{1'b0}} : {sample_s, sample_s};
                sdata_d = frame_s[FRAME_W-1];
                shift_d = frame_s << 1;
            end else begin
                sdata_d = shift_q[FRAME_W-1];
                shift_d = shift_q << 1;
            end
            if (bit_nxt_s == 5'd16) begin
                cke_d = 1'b1;
            end else begin
                cke_d = start_q;
            end
        end else begin
            bit_cnt_d = bit_cnt_q;
        end

        hold_vd_d = hold_vd_q & ~load_s;
        if (iSoundVd) begin
            hold_d    = iSound;
            hold_vd_d = 1'b1;
            ovr_d     = hold_vd_q & ~load_s;
        end else begin
            hold_d    = hold_q;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge iSysClk) begin
        if (iRst) begin
            div_q     <= '0;
            bclk_q    <= 1'b0;
            bit_cnt_q <= 5'd31;
            hold_q    <= '0;
            hold_vd_q <= 1'b0;
            last_q    <= '0;
            shift_q   <= '0;
            lrck_q    <= 1'b0;
            sdata_q   <= 1'b0;
            cke_q     <= 1'b0;
            und_q     <= 1'b0;
            ovr_q     <= 1'b0;
            start_q   <= 1'b1;
        end else begin
            div_q     <= div_d;
            bclk_q    <= bclk_d;
            bit_cnt_q <= bit_cnt_d;
            hold_q    <= hold_d;
            hold_vd_q <= hold_vd_d;
            last_q    <= last_d;
            shift_q   <= shift_d;
            lrck_q    <= lrck_d;
            sdata_q   <= sdata_d;
            cke_q     <= cke_d;
            und_q     <= und_d;
            ovr_q     <= ovr_d;
            start_q   <= start_d;
        end
    end

    assign oSoundCke = cke_q;
    assign oBclk     = bclk_q;
    assign oLrck     = lrck_q;
    assign oSdata    = sdata_q;
    assign oUnderrun = und_q;
    assign oOverrun  = ovr_q;

endmodule

// File: tb/tb_sound_i2s_tx.sv
// Scoreboard bench for sound_i2s_tx: the stimulus queues hand-computed frame words,
// a negedge monitor rebuilds frames from the I2S stream and checks timing every cycle.
module tb_sound_i2s_tx;

    localparam int D = 4;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic [15:0] sound = 16'h0000;
    logic        vd    = 1'b0;
    logic        mute  = 1'b0;
    logic        cke, bclk, lrck, sdata, und, ovr;

    int cyc    = -2;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] frame;
        logic        und;
        int          ovr;
    } exp_t;

    typedef struct {
        int          n;
        logic [15:0] s1;
        logic [15:0] s2;
        logic        coinc;
        logic [15:0] cval;
        logic        mute;
        logic [31:0] frame;
        logic        und;
        int          ovr;
    } vec_t;

    exp_t sb_q[$];

    sound_i2s_tx #(.pBclkDiv(D), .pSampleWidth(16)) dut (
        .iSysClk  (clk),
        .iRst     (rst),
        .iSound   (sound),
        .iSoundVd (vd),
        .iMute    (mute),
        .oSoundCke(cke),
        .oBclk    (bclk),
        .oLrck    (lrck),
        .oSdata   (sdata),
        .oUnderrun(und),
        .oOverrun (ovr)
    );

    always #5 clk = ~clk;

    // Cycle index relative to reset release: -1 while reset is sampled, 0 on the first free edge
    always @(posedge clk) cyc <= rst ? -1 : cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, got, exp);
        end
    endtask

    function automatic vec_t mk(input int n, input logic [15:0] s1, input logic [15:0] s2,
                                input logic co, input logic [15:0] cv, input logic mu,
                                input logic [31:0] fr, input logic un, input int ov);
        vec_t v;
        v.n = n; v.s1 = s1; v.s2 = s2; v.coinc = co; v.cval = cv; v.mute = mu;
        v.frame = fr; v.und = un; v.ovr = ov;
        return v;
    endfunction

    // Monitor: cycle-exact timing model plus frame reassembly against the scoreboard
    initial begin : monitor
        int          falls, pos;
        bit          fall_now, load_now, active;
        int          ovr_cnt, got_ovr;
        logic        got_und, prev_sdata;
        logic [31:0] cur;
        exp_t        e;
        active = 1'b0; ovr_cnt = 0; got_ovr = 0; got_und = 1'b0; prev_sdata = 1'b0; cur = 32'h0;
        forever begin
            @(negedge clk);
            if (cyc == -1) begin
                chk("reset_outputs", {26'h0, cke, bclk, lrck, sdata, und, ovr}, 32'h0);
                active = 1'b0; ovr_cnt = 0; prev_sdata = 1'b0;
            end else if (cyc >= 0) begin
                falls    = (cyc + 1) / (2 * D);
                pos      = (31 + falls) % 32;
                fall_now = ((cyc + 1) % (2 * D)) == 0;
                load_now = fall_now && (pos == 1);
                chk("bclk", bclk, ((cyc + 1) / D) % 2);
                chk("lrck", lrck, (falls == 0) ? 0 : ((pos >= 16) ? 1 : 0));
                chk("cke", cke, (cyc == 0 || (fall_now && pos == 16)) ? 1 : 0);
                if (!load_now) chk("underrun_idle", und, 0);
                if (!fall_now) chk("sdata_stable", sdata, prev_sdata);
                if (fall_now) begin
                    if (pos == 0 && active) begin
                        cur[0] = sdata;
                        if (sb_q.size() > 0) begin
                            e = sb_q.pop_front();
                            chk("frame_word", cur, e.frame);
                            chk("frame_underrun", got_und, e.und);
                            chk("frame_overruns", got_ovr, e.ovr);
                        end
                    end else if (pos >= 1) begin
                        if (pos == 1) begin
                            active  = 1'b1;
                            cur     = 32'h0;
                            got_und = und;
                            got_ovr = ovr_cnt;
                            ovr_cnt = 0;
                        end
                        if (active) cur[32 - pos] = sdata;
                    end
                end
                ovr_cnt    = ovr_cnt + (ovr ? 1 : 0);
                prev_sdata = sdata;
            end
        end
    end

    task automatic wait_cyc(input int x);
        while (cyc < x) @(negedge clk);
    endtask

    task automatic wait_cke(output int c, output bit ok);
        ok = 1'b0;
        c  = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (cke === 1'b1) begin
                c  = cyc;
                ok = 1'b1;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL cke_timeout (cycle %0d): got no request, expected one within 600 cycles", cyc);
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0) return;
        end
        checks++;
        errors++;
        $display("FAIL scoreboard_drain: got %0d pending frames, expected 0", sb_q.size());
    endtask

    // One frame of stimulus: answer the request, optionally overrun, mute or strobe on the load
    task automatic run_frame(input vec_t v);
        int   c, l, m;
        bit   ok;
        exp_t e;
        wait_cke(c, ok);
        if (!ok) return;
        m = 0;
        while (2 * (2 + 32 * m) * D - 1 <= c) m++;
        l = 2 * (2 + 32 * m) * D - 1;
        e.frame = v.frame; e.und = v.und; e.ovr = v.ovr;
        sb_q.push_back(e);
        if (v.n >= 1) begin
            wait_cyc(c + 2); vd = 1'b1; sound = v.s1;
            wait_cyc(c + 3); vd = 1'b0;
            if (v.n >= 2) begin
                chk("overrun_first", ovr, 0);
                wait_cyc(c + 4); vd = 1'b1; sound = v.s2;
                wait_cyc(c + 5); vd = 1'b0;
                chk("overrun_pulse", ovr, 1);
            end
        end
        wait_cyc(l - 1);
        mute = v.mute;
        if (v.coinc) begin
            vd = 1'b1; sound = v.cval;
        end
        wait_cyc(l);
        vd = 1'b0; mute = 1'b0;
        chk("overrun_at_load", ovr, 0);
    endtask

    vec_t ph1[11];
    vec_t ph2[2];

    initial begin : stimulus
        ph1[0]  = mk(1, 16'hA5C3, 16'h0000, 1'b0, 16'h0000, 1'b0, 32'hA5C3A5C3, 1'b0, 0);
        ph1[1]  = mk(1, 16'hA5C3, 16'h0000, 1'b0, 16'h0000, 1'b0, 32'hA5C3A5C3, 1'b0, 0);
        ph1[2]  = mk(1, 16'h1234, 16'h0000, 1'b0, 16'h0000, 1'b0, 32'h12341234, 1'b0, 0);
        ph1[3]  = mk(0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 32'h12341234, 1'b1, 0);
        ph1[4]  = mk(0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 32'h12341234, 1'b1, 0);
        ph1[5]  = mk(2, 16'h1111, 16'h2222, 1'b0, 16'h0000, 1'b0, 32'h22222222, 1'b0, 1);
        ph1[6]  = mk(1, 16'h7FFF, 16'h0000, 1'b0, 16'h0000, 1'b1, 32'h00000000, 1'b0, 0);
        ph1[7]  = mk(0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 32'h7FFF7FFF, 1'b1, 0);
        ph1[8]  = mk(1, 16'h5555, 16'h0000, 1'b1, 16'h0F0F, 1'b0, 32'h55555555, 1'b0, 0);
        ph1[9]  = mk(0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 32'h0F0F0F0F, 1'b0, 0);
        ph1[10] = mk(0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 32'h0F0F0F0F, 1'b1, 0);
        ph2[0]  = mk(0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 32'h00000000, 1'b1, 0);
        ph2[1]  = mk(1, 16'h8001, 16'h0000, 1'b0, 16'h0000, 1'b0, 32'h80018001, 1'b0, 0);

        rst = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 11; i++) run_frame(ph1[i]);
        wait_empty();

        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (cyc >= 0 && ((cyc + 1) / (2 * D)) >= 2 && ((31 + (cyc + 1) / (2 * D)) % 32) == 10) break;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("midframe_reset_outputs", {26'h0, cke, bclk, lrck, sdata, und, ovr}, 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) run_frame(ph2[i]);
        wait_empty();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        errors++;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
